// File: rtl/tile_writeback_if.sv
// Avalon-MM burst write bus between the tile writeback engine and memory.
`timescale 1ns/1ps
interface tile_writeback_if;
  logic [31:0] av_address;
  logic [3:0]  av_burstcount;
  logic [63:0] av_writedata;
  logic        av_write;
  logic        av_waitrequest;

  modport master (
    output av_address, av_burstcount, av_writedata, av_write,
    input  av_waitrequest
  );

  modport slave (
    input  av_address, av_burstcount, av_writedata, av_write,
    output av_waitrequest
  );
endinterface

// File: rtl/tile_writeback.sv
// Flushes one finished 32x32 16-bit tile from the 4-bank tile RAM to the
// framebuffer as 32 Avalon bursts of 8 x 64-bit beats, one burst per row.
`timescale 1ns/1ps
module tile_writeback #(
  parameter int FB_STRIDE = 1280,
  parameter int TILE_COLS = 20,
  parameter int TILE_ROWS = 15
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [5:0]  tile_x,
  input  logic [5:0]  tile_y,
  input  logic [31:0] fb_base,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic [7:0]  ram_addr,
  input  logic [63:0] ram_q,
  tile_writeback_if.master av
);

  localparam logic [31:0] STRIDE32   = 32'(FB_STRIDE);
  localparam logic [31:0] TILE_PITCH = 32'(FB_STRIDE * 32);

  typedef enum logic [1:0] {IDLE, SETUP, XFER, DONE} state_t;
  state_t state, state_nx;

  logic        in_range, accept, can_issue, push, pop, last_beat;
  logic [5:0]  tx_q, ty_q;
  logic [31:0] base_q;
  logic [8:0]  rd_word;          // next RAM word to read; bit 8 set = all issued
  logic        pend_a, pend_b;   // read in flight: address phase / data phase
  logic [63:0] fifo_mem [4];
  logic [1:0]  wr_ptr, rd_ptr;
  logic [2:0]  fifo_cnt, occ;
  logic [2:0]  beat_cnt;
  logic [4:0]  row_cnt;

  assign in_range  = ({26'd0, tile_x} < 32'(TILE_COLS)) && ({26'd0, tile_y} < 32'(TILE_ROWS));
  assign accept    = start && !busy && in_range;
  assign occ       = fifo_cnt + {2'd0, pend_a} + {2'd0, pend_b};
  assign can_issue = (state == SETUP || state == XFER) && !rd_word[8] && (occ < 3'd4);
  assign push      = pend_b;
  assign pop       = av.av_write && !av.av_waitrequest;
  assign last_beat = pop && (row_cnt == 5'd31) && (beat_cnt == 3'd7);

  // State register.
  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nx;
  end

  // Next-state logic; DONE behaves like IDLE for a new start so no request is lost.
  // NOTE: every combinational output gets a default first so no latch is inferred.
  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE, DONE: state_nx = accept ? SETUP : IDLE;
      SETUP:      state_nx = XFER;
      XFER:       if (last_beat) state_nx = DONE;
      default:    state_nx = IDLE;
    endcase
  end

  // Status and bus outputs decoded from the state and the FIFO head.
  always_comb begin
    busy            = (state == SETUP) || (state == XFER);
    done            = (state == DONE);
    av.av_write     = (state == XFER) && (fifo_cnt != 3'd0);
    av.av_writedata = av.av_write ? fifo_mem[rd_ptr] : 64'd0;
  end

  // Request latch and rejection pulse.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tx_q   <= '0;
      ty_q   <= '0;
      base_q <= '0;
      err    <= 1'b0;
    end else begin
      err <= start && !busy && !in_range;
      if (accept) begin
        tx_q   <= tile_x;
        ty_q   <= tile_y;
        base_q <= fb_base;
      end
    end
  end

  // RAM read issue: word 0 goes out with the accepted start, the rest are
  // throttled so FIFO contents plus reads in flight never exceed four.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_word  <= '0;
      ram_addr <= '0;
      pend_a   <= 1'b0;
      pend_b   <= 1'b0;
    end else begin
      pend_a <= accept || can_issue;
      pend_b <= pend_a;
      if (accept) begin
        ram_addr <= 8'd0;
        rd_word  <= 9'd1;
      end else if (can_issue) begin
        ram_addr <= rd_word[7:0];
        rd_word  <= rd_word + 9'd1;
      end
    end
  end

  // Prefetch FIFO storage.
  // NOTE: the data array is not reset; only pointers/count are, and the output is gated by av_write.
  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr] <= ram_q;
  end

  // Prefetch FIFO pointers and occupancy.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      fifo_cnt <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 2'd1;
      if (pop)  rd_ptr <= rd_ptr + 2'd1;
      fifo_cnt <= fifo_cnt + {2'd0, push} - {2'd0, pop};
    end
  end

  // Burst address and beat/row tracking; row address advances by the stride.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      av.av_address    <= '0;
      av.av_burstcount <= '0;
      beat_cnt         <= '0;
      row_cnt          <= '0;
    end else if (state == SETUP) begin
      av.av_address    <= base_q + 32'(ty_q) * TILE_PITCH + {20'd0, tx_q, 6'd0};
      av.av_burstcount <= 4'd8;
      beat_cnt         <= '0;
      row_cnt          <= '0;
    end else if (pop) begin
      beat_cnt <= beat_cnt + 3'd1;
      if (beat_cnt == 3'd7 && !last_beat) begin
        row_cnt       <= row_cnt + 5'd1;
        av.av_address <= av.av_address + STRIDE32;
      end
    end
  end

endmodule

// File: tb/tb_tile_writeback.sv
// Self-checking bench for tile_writeback: scoreboard of expected beats,
// full-speed and backpressured flushes, rejection and mid-flush reset.
`timescale 1ns/1ps
module tb_tile_writeback;
  localparam int FB_STRIDE = 1280;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [5:0]  tile_x = '0, tile_y = '0;
  logic [31:0] fb_base = '0;
  logic        busy, done, err;
  logic [7:0]  ram_addr;
  logic [63:0] ram_q;

  tile_writeback_if av_bus();

  tile_writeback #(.FB_STRIDE(FB_STRIDE), .TILE_COLS(20), .TILE_ROWS(15)) dut (
    .clk(clk), .rst(rst), .start(start), .tile_x(tile_x), .tile_y(tile_y),
    .fb_base(fb_base), .busy(busy), .done(done), .err(err),
    .ram_addr(ram_addr), .ram_q(ram_q), .av(av_bus.master)
  );

  always #5 clk = ~clk;

  // Tile RAM model: data valid one cycle after the address.
  logic [63:0] ram_mem [256];
  always @(posedge clk) ram_q <= ram_mem[ram_addr];

  typedef struct packed { logic [31:0] addr; logic [63:0] data; } beat_t;
  beat_t sb[$];

  int n_checks = 0, n_fail = 0;
  int cyc = 0, beats = 0, first_cyc = 0, last_cyc = 0;
  int done_cnt = 0, err_cnt = 0, write_cyc_cnt = 0;
  bit bp_en = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Backpressure driver.
  initial forever begin
    @(posedge clk);
    #1 av_bus.av_waitrequest = bp_en ? 1'($urandom_range(0, 1)) : 1'b0;
  end

  // Output monitor, sampled mid-cycle.
  initial begin
    bit          prev_stall;
    logic [31:0] prev_addr;
    logic [63:0] prev_data;
    beat_t       e;
    prev_stall = 1'b0;
    prev_addr  = '0;
    prev_data  = '0;
    forever begin
      @(negedge clk);
      if (!rst) begin
        prev_stall = 1'b0;
      end else begin
        if (av_bus.av_write) write_cyc_cnt++;
        if (prev_stall) begin
          check("stall_write_held", 64'(av_bus.av_write), 64'd1);
          check("stall_data_held", av_bus.av_writedata, prev_data);
          check("stall_addr_held", 64'(av_bus.av_address), 64'(prev_addr));
        end
        check("fifo_occ_le4", 64'(dut.fifo_cnt <= 3'd4), 64'd1);
        if (av_bus.av_write && !av_bus.av_waitrequest) begin
          if (beats == 0) first_cyc = cyc;
          last_cyc = cyc;
          beats++;
          check("beat_expected", 64'(sb.size() != 0), 64'd1);
          if (sb.size() != 0) begin
            e = sb.pop_front();
            check("beat_addr", 64'(av_bus.av_address), 64'(e.addr));
            check("beat_data", av_bus.av_writedata, e.data);
          end
          check("burstcount", 64'(av_bus.av_burstcount), 64'd8);
        end
        if (done) begin
          done_cnt++;
          check("done_busy_low", 64'(busy), 64'd0);
          check("done_after_last_beat", 64'(cyc - last_cyc), 64'd1);
        end
        if (err) err_cnt++;
        prev_stall = av_bus.av_write && av_bus.av_waitrequest;
        prev_addr  = av_bus.av_address;
        prev_data  = av_bus.av_writedata;
      end
    end
  end

  task automatic load_ram(input int pat);
    for (int n = 0; n < 256; n++) begin
      logic [7:0] b8;
      b8 = 8'(n);
      case (pat)
        0:       ram_mem[n] = {4{b8, b8}};
        1:       ram_mem[n] = {b8, 8'hB3, b8, 8'hB2, b8, 8'hB1, b8, 8'hB0};
        default: ram_mem[n] = {$urandom, $urandom};
      endcase
    end
  endtask

  // Push the 256 expected beats of a flush and clear per-flush statistics.
  task automatic expect_flush(input logic [5:0] tx, input logic [5:0] ty, input logic [31:0] base);
    sb.delete();
    beats = 0; first_cyc = 0; last_cyc = 0; done_cnt = 0;
    for (int r = 0; r < 32; r++) begin
      for (int k = 0; k < 8; k++) begin
        beat_t b;
        b.addr = base + 32'((int'(ty) * 32 + r) * FB_STRIDE) + 32'(int'(tx) * 64);
        b.data = ram_mem[r * 8 + k];
        sb.push_back(b);
      end
    end
  endtask

  // Called just after a rising edge; returns just after the edge that samples start.
  task automatic pulse_start(input logic [5:0] tx, input logic [5:0] ty,
                             input logic [31:0] base, output int sc);
    tile_x = tx; tile_y = ty; fb_base = base; start = 1'b1;
    @(negedge clk);
    sc = cyc;
    @(posedge clk);
    #1;
    start   = 1'b0;
    tile_x  = 6'($urandom);
    tile_y  = 6'($urandom);
    fb_base = $urandom;
  endtask

  task automatic wait_flush(input int sc, input bit full_speed);
    for (int i = 0; i < 3000; i++) begin
      @(posedge clk);
      if (done_cnt != 0) break;
    end
    check("flush_done_in_time", 64'(done_cnt != 0), 64'd1);
    repeat (5) @(posedge clk);
    #2;
    check("done_once", 64'(done_cnt), 64'd1);
    check("beat_total", 64'(beats), 64'd256);
    check("scoreboard_empty", 64'(sb.size()), 64'd0);
    check("first_write_latency", 64'((first_cyc - sc) <= 3), 64'd1);
    check("ram_addr_stopped", 64'(ram_addr), 64'd255);
    check("busy_after_flush", 64'(busy), 64'd0);
    if (full_speed) check("back_to_back_beats", 64'(last_cyc - first_cyc), 64'd255);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_busy"}, 64'(busy), 64'd0);
    check({tag, "_done"}, 64'(done), 64'd0);
    check({tag, "_err"}, 64'(err), 64'd0);
    check({tag, "_av_write"}, 64'(av_bus.av_write), 64'd0);
    check({tag, "_av_address"}, 64'(av_bus.av_address), 64'd0);
    check({tag, "_av_burstcount"}, 64'(av_bus.av_burstcount), 64'd0);
    check({tag, "_av_writedata"}, av_bus.av_writedata, 64'd0);
    check({tag, "_ram_addr"}, 64'(ram_addr), 64'd0);
  endtask

  initial begin
    int sc, sc2, e0, w0;
    av_bus.av_waitrequest = 1'b0;
    load_ram(0);
    #2 rst = 1'b0;
    #1 check_all_zero("reset");
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;

    // Full-speed flush, tile (2,1): first address 0x0010_A080.
    expect_flush(6'd2, 6'd1, 32'h0010_0000);
    pulse_start(6'd2, 6'd1, 32'h0010_0000, sc);
    check("busy_rise", 64'(busy), 64'd1);
    wait_flush(sc, 1'b1);

    // Lane mapping, last valid tile, address wraps modulo 2^32.
    load_ram(1);
    @(posedge clk); #1;
    expect_flush(6'd19, 6'd14, 32'hFFFF_0000);
    pulse_start(6'd19, 6'd14, 32'hFFFF_0000, sc);
    check("busy_rise_corner", 64'(busy), 64'd1);
    wait_flush(sc, 1'b1);

    // Random backpressure, plus a start while busy that must be ignored.
    load_ram(2);
    bp_en = 1'b1;
    @(posedge clk); #1;
    expect_flush(6'd0, 6'd0, 32'h2000_0004);
    pulse_start(6'd0, 6'd0, 32'h2000_0004, sc);
    repeat (20) @(posedge clk);
    #1 e0 = err_cnt;
    pulse_start(6'd5, 6'd5, 32'h0000_1234, sc2);
    check("busy_start_keeps_busy", 64'(busy), 64'd1);
    repeat (3) @(posedge clk);
    #1 check("busy_start_no_err", 64'(err_cnt - e0), 64'd0);
    wait_flush(sc, 1'b0);
    bp_en = 1'b0;

    // Rejected starts: tile_x out of range, then tile_y out of range.
    @(posedge clk); #1;
    e0 = err_cnt; w0 = write_cyc_cnt;
    pulse_start(6'd20, 6'd0, 32'h0, sc);
    check("reject_x_err_next", 64'(err), 64'd1);
    check("reject_x_busy", 64'(busy), 64'd0);
    repeat (4) @(posedge clk);
    #1 check("reject_x_err_once", 64'(err_cnt - e0), 64'd1);
    e0 = err_cnt;
    pulse_start(6'd3, 6'd15, 32'h0, sc);
    check("reject_y_err_next", 64'(err), 64'd1);
    check("reject_y_busy", 64'(busy), 64'd0);
    repeat (4) @(posedge clk);
    #1 check("reject_y_err_once", 64'(err_cnt - e0), 64'd1);
    check("reject_no_write", 64'(write_cyc_cnt - w0), 64'd0);

    // Reset at beat 100, then a fresh flush on the first edge after release.
    load_ram(0);
    @(posedge clk); #1;
    expect_flush(6'd7, 6'd3, 32'h0040_0000);
    pulse_start(6'd7, 6'd3, 32'h0040_0000, sc);
    for (int i = 0; i < 1000; i++) begin
      @(posedge clk);
      if (beats >= 100) break;
    end
    check("reached_beat_100", 64'(beats >= 100), 64'd1);
    @(negedge clk);
    #1 rst = 1'b0;
    #1 check_all_zero("midflush_reset");
    repeat (3) @(posedge clk);
    #1 check("abort_no_done", 64'(done_cnt), 64'd0);
    expect_flush(6'd4, 6'd9, 32'h0080_0000);
    @(posedge clk); #1;
    rst = 1'b1;
    pulse_start(6'd4, 6'd9, 32'h0080_0000, sc);
    check("busy_rise_after_reset", 64'(busy), 64'd1);
    wait_flush(sc, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/tile_writeback.md
TILE_WRITEBACK -- requirements
Module: tile_writeback

Interface
REQ-001 Parameter FB_STRIDE, default 1280, SHALL be the framebuffer line pitch in bytes.
REQ-002 Parameter TILE_COLS, default 20, SHALL be the number of tile columns on screen.
REQ-003 Parameter TILE_ROWS, default 15, SHALL be the number of tile rows on screen.
REQ-004 Port clk, input, 1 bit, SHALL be the single clock; all state is updated on its rising edge.
REQ-005 Port rst, input, 1 bit, SHALL be the asynchronous active-low reset.
REQ-006 Port start, input, 1 bit, SHALL be a one-cycle request to flush the finished tile.
REQ-007 Ports tile_x [5:0] and tile_y [5:0], input, SHALL be the tile coordinates, sampled with start.
REQ-008 Port fb_base, input, 32 bits, SHALL be the framebuffer byte base address, sampled with start.
REQ-009 Port busy, output, 1 bit, SHALL be high while a flush is in progress.
REQ-010 Port done, output, 1 bit, SHALL be a one-cycle pulse at flush completion.
REQ-011 Port err, output, 1 bit, SHALL be a one-cycle pulse when a start is rejected.
REQ-012 Port ram_addr, output, 8 bits, SHALL be the tile-RAM read address: {row[4:0], word[2:0]}.
REQ-013 Port ram_q, input, 64 bits, SHALL be the read data from the 4 banks; bank b is at [16b+15:16b], and the data is valid exactly 1 cycle after ram_addr.
REQ-014 Ports av_address [31:0], av_burstcount [3:0], av_writedata [63:0] and av_write [1], output, SHALL form the Avalon-MM burst write master.
REQ-015 Port av_waitrequest, input, 1 bit, SHALL stall the current beat while high.

Function
REQ-016 A start while busy=0 SHALL be accepted only if tile_x<TILE_COLS and tile_y<TILE_ROWS; otherwise it SHALL be ignored and err SHALL pulse on the next cycle.
REQ-017 A start while busy=1 SHALL be ignored silently, with no err pulse.
REQ-018 busy SHALL rise on the cycle after an accepted start.
REQ-019 The block SHALL latch tile_x, tile_y and fb_base at start; later changes to these inputs SHALL have no effect.
REQ-020 The state machine SHALL be: IDLE -> SETUP (1 cycle, computes the row-0 address) -> XFER (32 rows x 8 beats) -> DONE (1 cycle) -> IDLE.
REQ-021 The row r start address SHALL be fb_base + (tile_y*32 + r)*FB_STRIDE + tile_x*64, modulo 2^32; it SHALL be incremented by FB_STRIDE per row rather than re-multiplied.
REQ-022 Each row SHALL be one burst: av_burstcount=8; av_address held constant for all 8 beats of the burst.
REQ-023 A beat SHALL be accepted when av_write=1 and av_waitrequest=0.
REQ-024 av_writedata and av_write SHALL hold steady while av_waitrequest=1.
REQ-025 Beat k of row r SHALL carry RAM word {r,k}, with pixel X=4k in bits [15:0], passed through unmodified.
REQ-026 RAM reads SHALL be prefetched into a 4-entry FIFO; a read SHALL be issued only if FIFO occupancy plus in-flight reads is <4, so the FIFO never overflows.
REQ-027 With av_waitrequest held low, sustained throughput SHALL be 1 beat per cycle, including across row boundaries; the first av_write SHALL assert no later than 3 cycles after the accepted start.
REQ-028 av_write SHALL deassert only when the FIFO is empty (underflow), after the final beat, or in IDLE.
REQ-029 done SHALL pulse on the cycle after the 256th beat is accepted; busy SHALL fall in that same cycle.
REQ-030 ram_addr SHALL stop advancing after word 255 is read; no RAM reads SHALL be issued beyond the tile.

Reset
REQ-031 On rst=0, asynchronously: busy, done, err, av_write, av_address, av_burstcount, av_writedata and ram_addr SHALL go to 0; the FIFO SHALL empty; the state SHALL become IDLE.
REQ-032 A reset mid-flush SHALL abort the flush with no done pulse; the truncated burst is accepted system behaviour.
REQ-033 The first start is honoured on the first rising edge after rst deasserts.

Verification
REQ-034 Full-speed flush: fb_base=0x0010_0000, tile (2,1), waitrequest=0 -> 32 bursts; first address 0x0010_0000+32*1280+128=0x0010_A080; each following row +1280; 256 beats in 256 consecutive cycles; done exactly once.
REQ-035 Data ordering: RAM word n preloaded with {4{n[7:0],n[7:0]}} -> beat n carries that value; per-bank lane mapping checked.
REQ-036 Random backpressure: waitrequest random at 50% -> no beat lost or duplicated; data and address stable while stalled; FIFO occupancy never exceeds 4.
REQ-037 Rejection: start with tile_x=20 -> err pulses once; busy stays 0; no av_write. Start during busy -> ignored; the current flush is unaffected.
REQ-038 Reset at beat 100 -> all outputs 0 immediately; a new start then produces a correct full 256-beat flush.
